// File: rtl/pc_sequencer_if.sv
// Command and status bundle for the program-counter sequencer.
// The master drives command strobes and operands; the slave returns the PC and RAS status.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             load;
  logic             call;
  logic             ret;
  logic             branch;
  logic             increment;
  logic             err_clr;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, load, call, ret, branch, increment, err_clr, D, offset,
    input  Q, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, load, call, ret, branch, increment, err_clr, D, offset,
    output Q, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: step, load, relative branch and call/return.
// Return addresses live in a circular stack that overwrites its oldest entry when full.
module pc_sequencer #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned     RAS_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             clr,
  pc_sequencer_if.slave    bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_top;
  logic             r_empty;
  logic             r_full;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [PW-1:0]    w_top_nxt;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic             w_ovf_set;
  logic             w_unf_set;

  // Priority decode of the command strobes; everything is frozen while stalled.
  always_comb begin
    w_q_nxt     = r_q;
    w_count_nxt = r_count;
    w_top_nxt   = r_top;
    w_push      = 1'b0;
    w_push_data = r_q + STEP;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (!bus.stall) begin
      if (bus.load) begin
        w_q_nxt = bus.D;
      end else if (bus.call) begin
        w_push    = 1'b1;
        w_q_nxt   = bus.D;
        w_top_nxt = r_top + PW'(1);
        if (r_count == CW'(RAS_DEPTH)) begin
          w_ovf_set = 1'b1;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end else if (bus.ret) begin
        if (r_count == '0) begin
          w_unf_set = 1'b1;
        end else begin
          w_q_nxt     = r_ras[r_top];
          w_top_nxt   = r_top - PW'(1);
          w_count_nxt = r_count - CW'(1);
        end
      end else if (bus.branch) begin
        w_q_nxt = r_q + bus.offset;
      end else if (bus.increment) begin
        w_q_nxt = r_q + STEP;
      end
    end
  end

  // PC, stack pointer, count and sticky flags; a new error wins over err_clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_q     <= RESET_VALUE;
      r_count <= '0;
      r_top   <= '1;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_top   <= w_top_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(RAS_DEPTH));
      r_ovf   <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_unf   <= w_unf_set | (r_unf & ~bus.err_clr);
    end
  end

  // Stack storage carries no reset; entries past ras_count are never read.
  always_ff @(posedge clk) begin
    if (!clr && w_push) begin
      r_ras[w_top_nxt] <= w_push_data;
    end
  end

  assign bus.Q             = r_q;
  assign bus.ras_count     = r_count;
  assign bus.ras_empty     = r_empty;
  assign bus.ras_full      = r_full;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the datapath control unit.
- Holds the current PC, advances by a fixed step, and supports absolute load and PC-relative branch.
- Supports call/return through an internal return-address stack (RAS).
- The control FSM drives one-hot-ish strobes; Q feeds the MAR/bus. All state is registered on clk.

Parameters:
WIDTH, 32, PC/data width in bits (>= 8)
STEP, 1, increment amount per advance (unsigned, < 2^WIDTH)
RESET_VALUE, 0, PC value after clr
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
stall  input  1  freeze all state except clr and err_clr
load  input  1  Q <= D
call  input  1  push Q+STEP, then Q <= D
ret  input  1  pop top of RAS into Q
branch  input  1  Q <= Q + offset
increment  input  1  Q <= Q + STEP
err_clr  input  1  clear sticky error flags
D  input  WIDTH  absolute target for load/call
offset  input  WIDTH  two's-complement branch displacement
Q  output  WIDTH  current PC (registered)
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_empty  output  1  ras_count == 0
ras_full  output  1  ras_count == RAS_DEPTH
ras_overflow  output  1  sticky: call issued while full
ras_underflow  output  1  sticky: ret issued while empty

Behaviour:
- All updates occur on the rising clk edge. Outputs are registered and reflect a command in the cycle after the edge that samples it (1-cycle latency).
- clr (highest priority, ignores stall) sets:
  - Q = RESET_VALUE
  - ras_count = 0, ras_empty = 1, ras_full = 0
  - ras_overflow = 0, ras_underflow = 0
  - RAS contents become don't-care
  - clr mid-sequence discards any stacked returns.
- err_clr (ignores stall, lower priority than clr) clears both sticky flags. If err_clr coincides with a new error event in the same cycle, the flag is set (set wins).
- stall=1 and no clr: Q, the RAS and ras_count hold. err_clr still acts. All other strobes are ignored; they are not queued.
- Command priority when several strobes are high: load > call > ret > branch > increment. Only the winning command acts; no strobe high means hold.
- increment: Q = (Q + STEP) mod 2^WIDTH. Wraps silently (e.g. all-ones + 1 gives 0).
- branch: Q = (Q + offset) mod 2^WIDTH, with offset treated as signed. No overflow flag.
- load: Q = D. RAS untouched.
- call:
  - Pushes (Q + STEP) mod 2^WIDTH, then Q = D.
  - Not full: ras_count increments.
  - Full: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, ras_overflow = 1.
- ret:
  - Not empty: Q = top entry, ras_count decrements.
  - Empty: Q holds, ras_count stays 0, ras_underflow = 1.
- The RAS is a circular buffer with a top pointer of $clog2(RAS_DEPTH) bits; pointer arithmetic wraps modulo RAS_DEPTH.
- ras_empty and ras_full are derived from the registered ras_count and are consistent with it every cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset and increment: clr for 1 cycle, then increment for 3 cycles → Q = 0, 1, 2, 3; ras_empty = 1; both flags 0.
- Wrap and branch: load D=0xFFFFFFFF, then increment → Q = 0x00000000. Then load 0x100 and branch with offset 0xFFFFFFF0 (-16) → Q = 0xF0.
- Call/return nesting: from Q=0x10, call D=0x200, then call D=0x300 → ras_count = 2, Q = 0x300. ret → Q = 0x201. ret → Q = 0x11, ras_empty = 1.
- Overflow: 5 calls with D = 0x10, 0x20, 0x30, 0x40, 0x50 starting from Q=0 → ras_overflow = 1, ras_count = 4. Four rets return 0x41, 0x31, 0x21, 0x11 (0x01 is lost). A fifth ret leaves Q = 0x11 and sets ras_underflow = 1. err_clr then clears both flags.
- Priority and stall:
  - load, call, ret, branch and increment all high with D=0x80 → Q = 0x80, ras_count unchanged.
  - stall=1 with increment=1 for 4 cycles → Q constant.
  - stall=1 together with clr → Q = RESET_VALUE.
- Reset mid-operation: after 3 calls, assert clr → ras_count = 0 and Q = RESET_VALUE next cycle. A subsequent ret sets ras_underflow = 1 and Q holds.
